// File: rtl/term_writer.sv
// Character-RAM write sequencer for the serial text terminal: cursor tracking,
// control codes and form-feed screen clear. Option: TERM_WRITER_CLEAR_ON_RESET_EN.
module term_writer #(
    parameter int          MAXCOL = 59,
    parameter int          MAXLIN = 16,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [10:0] o_address,
    output logic [7:0]  o_data,
    output logic        o_we,
    output logic        o_busy,
    output logic [5:0]  o_col,
    output logic [4:0]  o_lin
);

    localparam logic [5:0] COL_LAST = 6'(MAXCOL);
    localparam logic [4:0] LIN_LAST = 5'(MAXLIN);

    typedef enum logic {IDLE, CLEAR} state_e;

`ifdef TERM_WRITER_CLEAR_ON_RESET_EN
    localparam state_e RST_STATE = CLEAR;
`else
    localparam state_e RST_STATE = IDLE;
`endif

    state_e      state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  lin_q, lin_d;
    logic [5:0]  ccol_q, ccol_d;
    logic [4:0]  clin_q, clin_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic        print;
    logic [4:0]  lin_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RST_STATE;
            col_q   <= '0;
            lin_q   <= '0;
            ccol_q  <= '0;
            clin_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            lin_q   <= lin_d;
            ccol_q  <= ccol_d;
            clin_q  <= clin_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    assign print   = (i_data >= 8'h20) && (i_data <= 8'h7E);
    assign lin_nxt = (lin_q == LIN_LAST) ? 5'd0 : lin_q + 5'd1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        lin_d   = lin_q;
        ccol_d  = ccol_q;
        clin_d  = clin_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    unique case (1'b1)
                        print: begin
                            addr_d = {lin_q, col_q};
                            data_d = i_data;
                            we_d   = 1'b1;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                lin_d = lin_nxt;
                            end else begin
                                col_d = col_q + 6'd1;
                            end
                        end
                        (i_data == 8'h0A): lin_d = lin_nxt;
                        (i_data == 8'h0D): col_d = '0;
                        (i_data == 8'h08): begin
                            if (col_q != 6'd0)
                                col_d = col_q - 6'd1;
                        end
                        (i_data == 8'h0C): begin
                            col_d   = '0;
                            lin_d   = '0;
                            ccol_d  = '0;
                            clin_d  = '0;
                            state_d = CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                addr_d = {clin_q, ccol_q};
                data_d = BLANK;
                we_d   = 1'b1;
                if (ccol_q == COL_LAST) begin
                    ccol_d = '0;
                    if (clin_q == LIN_LAST) begin
                        clin_d  = '0;
                        state_d = IDLE;
                    end else begin
                        clin_d = clin_q + 5'd1;
                    end
                end else begin
                    ccol_d = ccol_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_ready   = (state_q == IDLE);
    assign o_busy    = (state_q == CLEAR);
    assign o_address = addr_q;
    assign o_data    = data_q;
    assign o_we      = we_q;
    assign o_col     = col_q;
    assign o_lin     = lin_q;

endmodule
